// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t : FETCH / WAIT / HALTED controller states
//   DEF_ADDR_W    : default PC / instruction-memory address width
//   DEF_INSTR_W   : default instruction width
//   DEF_RESET_PC  : default PC loaded on reset
//   NOP           : bubble encoding, also the IF/ID instruction reset value
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W   = 16;
    localparam int unsigned DEF_INSTR_W  = 16;
    localparam logic [15:0] DEF_RESET_PC = 16'h0000;
    localparam logic [15:0] NOP          = 16'h0000;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory port of the fetch stage.
//   imem_req   : fetch request (fetch -> memory)
//   imem_addr  : fetch address (fetch -> memory)
//   imem_ready : imem_data valid this cycle for imem_addr (memory -> fetch)
//   imem_data  : fetched instruction (memory -> fetch)
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 16
) ();

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_data
    );

endinterface

// File: rtl/pc_reg.sv
// Architectural program counter.
//   clk, rst_n : clock, asynchronous active-low reset (to RESET_PC)
//   en         : update the PC this cycle
//   load       : 1 = take load_val, 0 = advance by 2
//   load_val   : value loaded when en & load
//   pc         : current PC
//   pc_plus2   : pc + 2, carry dropped
module pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus2
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Wraps modulo 2^ADDR_W, so the top even address rolls over to 0.
    assign pc_plus2 = pc_q + ADDR_W'(2);
    assign pc       = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (en) begin
            pc_d = load ? load_val : pc_plus2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches one instruction per cycle over a
// ready-handshaked memory port and fills the IF/ID register.
//   clk, rst_n     : clock, asynchronous active-low reset
//   pc_cur         : current PC (to PC-control)
//   pc_target      : redirect target (from PC-control), used only with redirect
//   redirect       : load pc_target and flush; beats stall and halt
//   stall          : hold PC and IF/ID
//   halt           : enter HALTED (sticky until reset)
//   imem           : instruction-memory port (master side)
//   ifid_valid     : IF/ID holds a real instruction
//   ifid_instr     : IF/ID instruction
//   ifid_pc_plus2  : IF/ID PC+2 of that instruction
//   halted         : core halted
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  pc_cur,
    input  logic [ADDR_W-1:0]  pc_target,
    input  logic               redirect,
    input  logic               stall,
    input  logic               halt,
    fetch_if.master            imem,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc_plus2,
    output logic               halted
);

    fetch_state_t state_q, state_d;

    logic               live;
    logic               accept;
    logic [ADDR_W-1:0]  pc_plus2;
    logic [ADDR_W-1:0]  target_even;

    logic               ifid_valid_q, ifid_valid_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]  ifid_pc2_q, ifid_pc2_d;

    assign live        = (state_q != HALTED);
    assign accept      = imem.imem_ready & ~stall & ~redirect & ~halt;
    // Targets are architecturally even; clear bit 0 rather than trust the source.
    assign target_even = pc_target & ~ADDR_W'(1);

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (live & (redirect | accept)),
        .load     (redirect),
        .load_val (target_even),
        .pc       (pc_cur),
        .pc_plus2 (pc_plus2)
    );

    // FSM next state. WAIT only records that the current fetch is outstanding;
    // the request itself looks the same as in FETCH.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH, WAIT: begin
                if (redirect) begin
                    state_d = FETCH;
                end else if (halt) begin
                    state_d = HALTED;
                end else if (!imem.imem_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = FETCH;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // IF/ID next state. A stalled response is dropped; the same address stays
    // on the bus so the word is fetched again once the stall clears.
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc2_d   = ifid_pc2_q;
        if (live) begin
            if (redirect || halt) begin
                ifid_valid_d = 1'b0;
            end else if (stall) begin
                ifid_valid_d = ifid_valid_q;
            end else if (imem.imem_ready) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = imem.imem_data;
                ifid_pc2_d   = pc_plus2;
            end else begin
                ifid_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= INSTR_W'(NOP);
            ifid_pc2_q   <= '0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc2_q   <= ifid_pc2_d;
        end
    end

    // Request is gated by rst_n so nothing is asked of memory while in reset.
    assign imem.imem_req  = rst_n & live;
    assign imem.imem_addr = pc_cur;

    assign ifid_valid    = ifid_valid_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_pc_plus2 = ifid_pc2_q;
    assign halted        = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc_cur;
    logic [15:0] pc_target = 16'h0;
    logic        redirect = 1'b0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        halted;
    logic        ready = 1'b0;
    logic [15:0] salt = 16'h0;

    int total = 0;
    int bad   = 0;

    fetch_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

    // Memory: word = address ^ salt, answered combinationally when ready.
    assign bus.imem_ready = ready;
    assign bus.imem_data  = bus.imem_addr ^ salt;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_cur        (pc_cur),
        .pc_target     (pc_target),
        .redirect      (redirect),
        .stall         (stall),
        .halt          (halt),
        .imem          (bus),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        stl;
        logic        red;
        logic        hlt;
        logic [15:0] tgt;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_pc2;
        logic [15:0] e_pc;
        logic        e_halted;
    } vec_t;

    vec_t vecs[20];

    // Behavioural reference state.
    logic        m_valid;
    logic [15:0] m_instr;
    logic [15:0] m_pc2;
    logic [15:0] m_pc;
    logic        m_halted;

    function automatic vec_t mk(input logic r, input logic s, input logic d, input logic h,
                                input logic [15:0] t, input logic ev, input logic [15:0] ei,
                                input logic [15:0] ep2, input logic [15:0] ep,
                                input logic eh);
        vec_t v;
        v.rdy = r; v.stl = s; v.red = d; v.hlt = h; v.tgt = t;
        v.e_valid = ev; v.e_instr = ei; v.e_pc2 = ep2; v.e_pc = ep; v.e_halted = eh;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic d, input logic h,
                         input logic [15:0] t);
        ready = r; stall = s; redirect = d; halt = h; pc_target = t;
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [15:0] ei,
                             input logic [15:0] ep2, input logic [15:0] ep, input logic eh);
        chk({tag, ".pc"}, 32'(pc_cur), 32'(ep));
        chk({tag, ".addr"}, 32'(bus.imem_addr), 32'(ep));
        chk({tag, ".req"}, 32'(bus.imem_req), 32'(!eh));
        chk({tag, ".halted"}, 32'(halted), 32'(eh));
        chk({tag, ".valid"}, 32'(ifid_valid), 32'(ev));
        if (ev) begin
            chk({tag, ".instr"}, 32'(ifid_instr), 32'(ei));
            chk({tag, ".pc2"}, 32'(ifid_pc_plus2), 32'(ep2));
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".rst_pc"}, 32'(pc_cur), 32'h0);
        chk({tag, ".rst_req"}, 32'(bus.imem_req), 32'h0);
        chk({tag, ".rst_valid"}, 32'(ifid_valid), 32'h0);
        chk({tag, ".rst_instr"}, 32'(ifid_instr), 32'h0);
        chk({tag, ".rst_pc2"}, 32'(ifid_pc_plus2), 32'h0);
        chk({tag, ".rst_halted"}, 32'(halted), 32'h0);
    endtask

    // Called at posedge+1: assert reset asynchronously, check, then release.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        #2;
        check_reset_values(tag);
        cycle();
        rst_n = 1'b1;
        #1;
        chk({tag, ".first_req"}, 32'(bus.imem_req), 32'h1);
        chk({tag, ".first_addr"}, 32'(bus.imem_addr), 32'h0);
        m_valid = 1'b0; m_instr = 16'h0; m_pc2 = 16'h0; m_pc = 16'h0; m_halted = 1'b0;
    endtask

    // Apply one cycle of inputs to the reference model.
    task automatic model_step(input logic r, input logic s, input logic d, input logic h,
                              input logic [15:0] t);
        if (!m_halted) begin
            if (d) begin
                m_pc    = {t[15:1], 1'b0};
                m_valid = 1'b0;
            end else if (h) begin
                m_halted = 1'b1;
                m_valid  = 1'b0;
            end else if (s) begin
                // everything held
            end else if (r) begin
                m_instr = m_pc ^ salt;
                m_pc2   = m_pc + 16'd2;
                m_valid = 1'b1;
                m_pc    = m_pc + 16'd2;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 0, 0, 16'd0,    1, 16'd0,    16'd2,    16'd2,    0);
        vecs[1]  = mk(1, 0, 0, 0, 16'd0,    1, 16'd2,    16'd4,    16'd4,    0);
        vecs[2]  = mk(1, 0, 0, 0, 16'd0,    1, 16'd4,    16'd6,    16'd6,    0);
        vecs[3]  = mk(1, 0, 1, 0, 16'd10,   0, 16'd0,    16'd0,    16'd10,   0);
        vecs[4]  = mk(0, 0, 0, 0, 16'd0,    0, 16'd0,    16'd0,    16'd10,   0);
        vecs[5]  = mk(0, 0, 0, 0, 16'd0,    0, 16'd0,    16'd0,    16'd10,   0);
        vecs[6]  = mk(0, 0, 0, 0, 16'd0,    0, 16'd0,    16'd0,    16'd10,   0);
        vecs[7]  = mk(1, 0, 0, 0, 16'd0,    1, 16'd10,   16'd12,   16'd12,   0);
        vecs[8]  = mk(1, 0, 1, 0, 16'd19,   0, 16'd0,    16'd0,    16'd18,   0);
        vecs[9]  = mk(1, 0, 0, 0, 16'd0,    1, 16'd18,   16'd20,   16'd20,   0);
        vecs[10] = mk(1, 1, 0, 0, 16'd0,    1, 16'd18,   16'd20,   16'd20,   0);
        vecs[11] = mk(1, 1, 0, 0, 16'd0,    1, 16'd18,   16'd20,   16'd20,   0);
        vecs[12] = mk(1, 0, 0, 0, 16'd0,    1, 16'd20,   16'd22,   16'd22,   0);
        vecs[13] = mk(1, 1, 1, 0, 16'd1000, 0, 16'd0,    16'd0,    16'd1000, 0);
        vecs[14] = mk(1, 0, 0, 0, 16'd0,    1, 16'd1000, 16'd1002, 16'd1002, 0);
        vecs[15] = mk(0, 1, 0, 0, 16'd0,    1, 16'd1000, 16'd1002, 16'd1002, 0);
        vecs[16] = mk(0, 0, 1, 0, 16'd100,  0, 16'd0,    16'd0,    16'd100,  0);
        vecs[17] = mk(1, 1, 0, 1, 16'd0,    0, 16'd0,    16'd0,    16'd100,  1);
        vecs[18] = mk(1, 0, 1, 0, 16'd8,    0, 16'd0,    16'd0,    16'd100,  1);
        vecs[19] = mk(1, 0, 0, 0, 16'd0,    0, 16'd0,    16'd0,    16'd100,  1);

        m_valid = 1'b0; m_instr = 16'h0; m_pc2 = 16'h0; m_pc = 16'h0; m_halted = 1'b0;

        // Reset held from time 0.
        #2;
        check_reset_values("init");
        cycle();
        cycle();
        rst_n = 1'b1;
        #1;
        chk("init.first_req", 32'(bus.imem_req), 32'h1);
        chk("init.first_addr", 32'(bus.imem_addr), 32'h0);

        // Directed table, memory word = address.
        salt = 16'h0;
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rdy, vecs[i].stl, vecs[i].red, vecs[i].hlt, vecs[i].tgt);
            cycle();
            check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr,
                      vecs[i].e_pc2, vecs[i].e_pc, vecs[i].e_halted);
        end

        // Reset out of HALTED.
        do_reset("rst_halted");

        // Wrap at the top of the address space.
        drive(1, 0, 1, 0, 16'hFFFE);
        cycle();
        check_all("wrap_redir", 1'b0, 16'h0, 16'h0, 16'hFFFE, 1'b0);
        drive(1, 0, 0, 0, 16'h0);
        cycle();
        check_all("wrap", 1'b1, 16'hFFFE, 16'h0000, 16'h0000, 1'b0);

        // Reset while a fetch is outstanding.
        drive(1, 0, 1, 0, 16'd40);
        cycle();
        drive(0, 0, 0, 0, 16'h0);
        cycle();
        check_all("wait", 1'b0, 16'h0, 16'h0, 16'd40, 1'b0);
        do_reset("rst_wait");

        // Randomized run against the reference model.
        salt = 16'(($urandom() & 32'hFFFF) | 32'h0100);
        for (int c = 0; c < 1500; c++) begin
            logic r, s, d, h;
            logic [15:0] t;
            if ((m_halted && $urandom_range(0, 4) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset($sformatf("rnd_rst%0d", c));
            end else begin
                r = ($urandom_range(0, 9) < 7);
                s = ($urandom_range(0, 4) == 0);
                d = ($urandom_range(0, 9) == 0);
                h = ($urandom_range(0, 59) == 0);
                t = 16'($urandom());
                drive(r, s, d, h, t);
                model_step(r, s, d, h, t);
                cycle();
                check_all($sformatf("rnd%0d", c), m_valid, m_instr, m_pc2, m_pc, m_halted);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
